// File: rtl/timebase_shifter_sequencer_pkg.sv
// Shared types and helpers for the timebase shifter sequencer.
// Holds the sequencer state encoding and the config address width calculation.
package timebase_shifter_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        RUN   = 2'd3
    } seq_state_t;

    // A single channel still needs a one-bit address port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shifter_channel_slot.sv
// Per-channel slot: shadow delay register, done flag and run output for one shifter core.
// Drives the core's load value and gates its decrement enable so it never underflows.
module shifter_channel_slot
    import timebase_shifter_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clockIn,
    input  logic                     reset,
    input  seq_state_t               state,
    input  logic                     stop,
    input  logic                     wr_sel,
    input  logic [COUNTER_WIDTH-1:0] cfg_data,
    input  logic [COUNTER_WIDTH-1:0] count_out,
    output logic [COUNTER_WIDTH-1:0] core_count_in,
    output logic                     core_enable,
    output logic                     run,
    output logic                     done
);

    logic [COUNTER_WIDTH-1:0] shadow;

    assign core_count_in = shadow;
    assign core_enable   = (state == COUNT) && !done && (count_out != '0);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            done   <= 1'b0;
            run    <= 1'b0;
        end else begin
            if (wr_sel) begin
                shadow <= cfg_data;
            end
            // An abort must win over a channel finishing on the same edge.
            if (stop || state == IDLE || state == LOAD) begin
                done <= 1'b0;
                run  <= 1'b0;
            end else if (state == COUNT && !done && count_out == '0) begin
                done <= 1'b1;
                run  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/timebase_shifter_sequencer.sv
// Sequences N down-counting shifter cores: loads all shadow delays at once, counts them
// down and raises each channel's run output once its delay has expired.
module timebase_shifter_sequencer
    import timebase_shifter_sequencer_pkg::*;
#(
    parameter int N_CHANNELS    = 3,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                                clockIn,
    input  logic                                reset,
    input  logic                                cfg_write,
    input  logic [addr_width(N_CHANNELS)-1:0]   cfg_addr,
    input  logic [COUNTER_WIDTH-1:0]            cfg_data,
    input  logic                                start,
    input  logic                                stop,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] core_count_out,
    output logic [N_CHANNELS-1:0]               core_load,
    output logic [N_CHANNELS-1:0]               core_enable,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] core_count_in,
    output logic [N_CHANNELS-1:0]               run,
    output logic                                busy
);

    localparam int ADDR_W = addr_width(N_CHANNELS);

    seq_state_t            state;
    logic [N_CHANNELS-1:0] done;
    logic                  all_done;

    assign all_done  = &done;
    assign busy      = (state != IDLE);
    assign core_load = {N_CHANNELS{state == LOAD}};

    for (genvar n = 0; n < N_CHANNELS; n++) begin : g_slot
        // Out-of-range addresses match no slot, so such writes are dropped.
        shifter_channel_slot #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_slot (
            .clockIn      (clockIn),
            .reset        (reset),
            .state        (state),
            .stop         (stop),
            .wr_sel       (cfg_write && (cfg_addr == ADDR_W'(n))),
            .cfg_data     (cfg_data),
            .count_out    (core_count_out[n*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .core_count_in(core_count_in[n*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .core_enable  (core_enable[n]),
            .run          (run[n]),
            .done         (done[n])
        );
    end

    // stop is checked first everywhere so it outranks start and completion.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state <= LOAD;
                LOAD:    state <= stop ? IDLE : COUNT;
                COUNT: begin
                    if (stop)          state <= IDLE;
                    else if (all_done) state <= RUN;
                end
                RUN:     if (stop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timebase_shifter_sequencer.sv
// Directed bench for timebase_shifter_sequencer with a behavioural model of the shifter cores.
module tb_timebase_shifter_sequencer;
    import timebase_shifter_sequencer_pkg::*;

    localparam int N = 3;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_write = 1'b0;
    logic [1:0]     cfg_addr = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [N*W-1:0] core_count_out;
    logic [N-1:0]   core_load;
    logic [N-1:0]   core_enable;
    logic [N*W-1:0] core_count_in;
    logic [N-1:0]   run;
    logic           busy;

    int errors = 0;
    int checks = 0;
    logic en0_seen;
    logic underflow_seen = 1'b0;
    logic [W-1:0] core_cnt [N];

    timebase_shifter_sequencer #(.N_CHANNELS(N), .COUNTER_WIDTH(W)) dut (
        .clockIn       (clk),
        .reset         (rst_n),
        .cfg_write     (cfg_write),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .start         (start),
        .stop          (stop),
        .core_count_out(core_count_out),
        .core_load     (core_load),
        .core_enable   (core_enable),
        .core_count_in (core_count_in),
        .run           (run),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Shifter core model: load wins, otherwise decrement when enabled.
    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < N; n++) begin
            if (!rst_n) begin
                core_cnt[n] <= '0;
            end else if (core_load[n]) begin
                core_cnt[n] <= core_count_in[n*W +: W];
            end else if (core_enable[n]) begin
                if (core_cnt[n] == '0) underflow_seen <= 1'b1;
                core_cnt[n] <= core_cnt[n] - 1'b1;
            end
        end
    end

    always_comb begin
        core_count_out = '0;
        for (int n = 0; n < N; n++) core_count_out[n*W +: W] = core_cnt[n];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [W-1:0] val);
        cfg_write = 1'b1;
        cfg_addr  = ch;
        cfg_data  = val;
        step();
        cfg_write = 1'b0;
    endtask

    task automatic stop_seq(input string name);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (run !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_stop: run=%b busy=%b, expected run=000 busy=0", name, run, busy);
        end
    endtask

    // Starts a sequence (start sampled at edge E) and checks run at edges E+1..E+kmax
    // against the expected rise edges r0..r2. Optionally writes a shadow at edge E+wr_k.
    task automatic run_seq(input int r0, input int r1, input int r2, input int kmax,
                           input int wr_k, input logic [1:0] wr_ch, input logic [W-1:0] wr_val,
                           input string name);
        logic [N-1:0] exp_run;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (core_load !== 3'b111 || busy !== 1'b1 || run !== 3'b000) begin
            errors++;
            $display("FAIL %s_load: core_load=%b busy=%b run=%b, expected 111/1/000",
                     name, core_load, busy, run);
        end
        en0_seen = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            if (k == wr_k) begin
                cfg_write = 1'b1;
                cfg_addr  = wr_ch;
                cfg_data  = wr_val;
            end
            step();
            cfg_write = 1'b0;
            if (core_enable[0]) en0_seen = 1'b1;
            exp_run = {k >= r2, k >= r1, k >= r0};
            checks++;
            if (run !== exp_run || busy !== 1'b1 || core_load !== 3'b000) begin
                errors++;
                $display("FAIL %s_run@E+%0d: run=%b busy=%b core_load=%b, expected run=%b busy=1 core_load=000",
                         name, k, run, busy, core_load, exp_run);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (run !== 3'b000 || busy !== 1'b0 || core_load !== 3'b000 ||
            core_enable !== 3'b000 || core_count_in !== '0) begin
            errors++;
            $display("FAIL reset: run=%b busy=%b load=%b en=%b cin=%h, expected all zero",
                     run, busy, core_load, core_enable, core_count_in);
        end
        #12 rst_n = 1'b1;
        step();
    endtask

    task automatic test_staggered();
        write_cfg(2'd0, 16'd0);
        write_cfg(2'd1, 16'd5);
        write_cfg(2'd2, 16'd12);
        run_seq(2, 7, 14, 15, -1, 2'd0, '0, "stagger");
        checks++;
        if (en0_seen !== 1'b0) begin
            errors++;
            $display("FAIL stagger_en0: core_enable[0] seen=%b, expected 0", en0_seen);
        end
        checks++;
        if (dut.state !== RUN) begin
            errors++;
            $display("FAIL stagger_state: state=%0d, expected RUN", dut.state);
        end
        stop_seq("stagger");
    endtask

    task automatic test_equal();
        write_cfg(2'd0, 16'd8);
        write_cfg(2'd1, 16'd8);
        write_cfg(2'd2, 16'd8);
        run_seq(10, 10, 10, 10, -1, 2'd0, '0, "equal");
        checks++;
        if (dut.state !== COUNT) begin
            errors++;
            $display("FAIL equal_state_e10: state=%0d, expected COUNT", dut.state);
        end
        step();
        checks++;
        if (dut.state !== RUN || run !== 3'b111) begin
            errors++;
            $display("FAIL equal_state_e11: state=%0d run=%b, expected RUN/111", dut.state, run);
        end
        stop_seq("equal");
    endtask

    task automatic test_abort();
        logic bad;
        write_cfg(2'd0, 16'd10);
        write_cfg(2'd1, 16'd10);
        write_cfg(2'd2, 16'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (core_enable !== 3'b000 || busy !== 1'b0 || run !== 3'b000) begin
            errors++;
            $display("FAIL abort: en=%b busy=%b run=%b, expected 000/0/000", core_enable, busy, run);
        end
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (run !== 3'b000 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: run or busy asserted after abort, got %b expected 0", bad);
        end
        run_seq(12, 12, 12, 12, -1, 2'd0, '0, "rerun");
        stop_seq("rerun");
    endtask

    task automatic test_midwrite();
        write_cfg(2'd0, 16'd9);
        write_cfg(2'd1, 16'd9);
        write_cfg(2'd2, 16'd9);
        run_seq(11, 11, 11, 11, 4, 2'd1, 16'd3, "midwrite");
        stop_seq("midwrite");
        run_seq(11, 5, 11, 11, -1, 2'd0, '0, "newshadow");
        stop_seq("newshadow");
    endtask

    task automatic test_ignore();
        write_cfg(2'd3, 16'd7);
        checks++;
        if (core_count_in !== {16'd9, 16'd3, 16'd9}) begin
            errors++;
            $display("FAIL bad_addr: core_count_in=%h, expected 0009_0003_0009", core_count_in);
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || core_load !== 3'b000) begin
            errors++;
            $display("FAIL start_stop_e: busy=%b core_load=%b, expected 0/000", busy, core_load);
        end
        step();
        checks++;
        if (busy !== 1'b0 || core_load !== 3'b000) begin
            errors++;
            $display("FAIL start_stop_e1: busy=%b core_load=%b, expected 0/000", busy, core_load);
        end
        run_seq(11, 5, 11, 11, -1, 2'd0, '0, "after_ignore");
        stop_seq("after_ignore");
    endtask

    task automatic test_reset_mid();
        write_cfg(2'd0, 16'd10);
        write_cfg(2'd1, 16'd20);
        write_cfg(2'd2, 16'd30);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (run !== 3'b000 || busy !== 1'b0 || core_load !== 3'b000 ||
            core_enable !== 3'b000 || core_count_in !== '0) begin
            errors++;
            $display("FAIL reset_mid: run=%b busy=%b load=%b en=%b cin=%h, expected all zero",
                     run, busy, core_load, core_enable, core_count_in);
        end
        #2 rst_n = 1'b1;
        step();
        run_seq(2, 2, 2, 3, -1, 2'd0, '0, "post_reset");
        stop_seq("post_reset");
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_equal();
        test_abort();
        test_midwrite();
        test_ignore();
        test_reset_mid();
        checks++;
        if (underflow_seen !== 1'b0) begin
            errors++;
            $display("FAIL underflow: enable seen at count 0 = %b, expected 0", underflow_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timebase_shifter_sequencer.md
Name: timebase_shifter_sequencer

Overview:
- Sequences N down-counting timebase shifter cores, which provide per-channel phase delay.
- Holds a shadow delay value per channel. On a start request it loads every core in one cycle, then enables each core's countdown.
- Asserts a per-channel run output once that channel's delay has expired.
- Sits between the PWM generator's register interface and the shifter cores. The run outputs drive the enables of the PWM carrier counters.

Parameters:
- N_CHANNELS, 3, number of shifter cores sequenced
- COUNTER_WIDTH, 16, width of each delay count

Ports:
- clockIn  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfg_write  in  1  shadow-register write strobe
- cfg_addr  in  $clog2(N_CHANNELS) (min 1)  channel index for the write
- cfg_data  in  COUNTER_WIDTH  delay value for the write
- start  in  1  start request, level or pulse; sampled only in IDLE
- stop  in  1  abort/stop request
- core_count_out  in  N_CHANNELS*COUNTER_WIDTH  count outputs of the cores, channel n at bits [n*W +: W]
- core_load  out  N_CHANNELS  per-core load strobe
- core_enable  out  N_CHANNELS  per-core decrement enable
- core_count_in  out  N_CHANNELS*COUNTER_WIDTH  values loaded into the cores
- run  out  N_CHANNELS  per-channel delayed enable for the PWM counters
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-low): state IDLE, all shadows 0, done flags 0, all outputs 0.
- Config writes:
  - Accepted in every state; shadow[cfg_addr] <= cfg_data.
  - cfg_addr >= N_CHANNELS: write ignored.
  - Shadows never affect a running sequence; they are consumed only at the next LOAD.
- core_count_in is driven combinationally from the shadows at all times.
- FSM (registered):
  - IDLE: start=1 and stop=0 -> LOAD. The start edge is edge E.
  - LOAD: one cycle, core_load all ones. -> COUNT at edge E+1 (cores capture their shadow values there).
  - COUNT:
    - core_enable[n] = !done[n] && core_count_out[n] != 0 (combinational).
    - A channel whose count_out is 0 and whose done flag is clear sets done[n] and run[n] at the next edge.
    - Once all done flags are set -> RUN.
  - RUN: all run bits held high. stop -> IDLE.
- stop in LOAD or COUNT: abort -> IDLE at the next edge; core_enable, core_load, run and done all clear.
- stop has priority over start on the same edge.
- start is ignored outside IDLE.
- cfg_write and start on the same edge in IDLE: LOAD uses the newly written value.
- Latency: a delay value D gives run[n] rising at edge E+D+2. D=0 gives E+2, with core_enable[n] never asserted.
- Count wrap: core_enable[n] is never asserted while count_out[n]==0, so cores never underflow.
- Channels finishing on the same cycle set their run bits on the same edge.
- Leaving RUN or aborting clears all done flags.
- No timeout: if a core never reaches 0, the sequence stays in COUNT until stop.

Decomposition:
- Shared package (pwm pkg):
  - typedef enum logic [1:0] seq_state_t {IDLE, LOAD, COUNT, RUN}.
  - Function for address width computation.
- Sub-module shifter_channel_slot, one per channel via generate:
  - Holds the shadow register, done flag and run register.
  - Produces core_enable and core_count_in for its channel.
  - Inputs: state, write-select, core_count_out slice.
- The top level holds the FSM and the all-done reduction.

Test Plan:
- Reset mid-COUNT (shadows 10/20/30, assert reset at E+5) -> all outputs 0 immediately; shadows read back 0 on the next sequence (all run at E'+2).
- Shadows 0, 5, 12; pulse start -> core_load=111 for one cycle; run rises at edges E+2, E+7, E+14; busy high throughout; core_enable[0] never high.
- Equal shadows 8/8/8 -> all run bits rise together at E+10; FSM enters RUN one cycle later; stop -> IDLE, run=000 next edge.
- stop at E+4 with shadows 10/10/10 -> core_enable=000 and IDLE next edge; run never asserted; new start re-runs from full value 10.
- cfg_write ch1=3 during COUNT of a sequence using 9 -> run[1] at E+11; next sequence gives run[1] at E'+5.
- cfg_write with cfg_addr=3 (N=3) -> no shadow change; start and stop on the same edge in IDLE -> stays IDLE, core_load never asserted.
